uart_tx_buffer: RTL and testbench

- Byte FIFO plus handshake sequencer that sits directly upstream of the UART transmitter top.
- Accepts bursts of bytes from a producer and drives the transmitter's `TX_Data`/`transmit` inputs one byte at a time, pacing on its `busy` output.
- Lets firmware or a packet source queue multiple bytes without polling `busy`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_buffer_if.sv | 29 ++
 rtl/uart_tx_buffer_sync_fifo.sv | 87 ++++++++
 rtl/uart_tx_buffer.sv | 98 +++++++++
 tb/tb_uart_tx_buffer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: the tx-side sequencer state encoding and default
// byte width, shared with the transmitter and receiver.
package uart_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

    // Width of an occupancy counter that must be able to hold the value depth.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer/transmitter-facing signal bundle of uart_tx_buffer.
// master = producer + transmitter side, slave = the buffer itself.
interface uart_tx_buffer_if
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          full;
    logic                          empty;
    logic [count_width(DEPTH)-1:0] count;
    logic                          overflow;
    logic [DATA_WIDTH-1:0]         TX_Data;
    logic                          transmit;
    logic                          busy;

    modport master (
        output wr_en, wr_data, busy,
        input  full, empty, count, overflow, TX_Data, transmit
    );

    modport slave (
        input  wr_en, wr_data, busy,
        output full, empty, count, overflow, TX_Data, transmit
    );

endinterface

// File: rtl/uart_tx_buffer_sync_fifo.sv
// Synchronous byte FIFO: register array, naturally wrapping pointers and
// registered count/full/empty flags. The head entry is always visible on
// o_rd_data; a pop only advances the read pointer.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_wr_en,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic                          i_rd_en,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [count_width(DEPTH)-1:0] o_count
);
    localparam int            AW         = $clog2(DEPTH);
    localparam int            CW         = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_wr;
    logic                  w_rd;
    logic [CW-1:0]         w_count_next;

    // Full is judged on the registered flag, so a write into a full FIFO is
    // rejected even if a pop happens on the same edge.
    assign w_wr = i_wr_en && !r_full;
    assign w_rd = i_rd_en && !r_empty;

    // Occupancy after this edge; a simultaneous write and pop cancel out.
    always_comb begin
        // NOTE: default assignment first so every path drives w_count_next and no latch is inferred.
        w_count_next = r_count;
        if (w_wr && !w_rd) begin
            w_count_next = r_count + CW'(1);
        end else if (w_rd && !w_wr) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // Pointers, count and flags; flags are derived from the next count so they
    // are registered yet reflect the current edge's write/pop.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage array; entries are only ever read after being written.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; pointers and count define validity.
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus handshake sequencer feeding a UART transmitter. Pops one
// byte at a time onto TX_Data, raises transmit until the transmitter reports
// busy, waits for busy to drop, then leaves one gap cycle before the next byte.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_tx_buffer_if.slave            bus
);
    localparam int CW = count_width(DEPTH);

    tx_state_e             r_state;
    logic                  r_transmit;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_overflow;

    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;

    sync_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (bus.wr_en),
        .i_wr_data  (bus.wr_data),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // The head is consumed exactly on the IDLE->REQ edge.
    assign w_pop = (r_state == ST_IDLE) && !w_empty;

    // Handshake sequencer with registered transmit/TX_Data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_transmit <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state    <= ST_REQ;
                        r_tx_data  <= w_head;
                        r_transmit <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // No timeout: wait as long as the transmitter needs.
                    if (bus.busy) begin
                        r_state    <= ST_SEND;
                        r_transmit <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (!bus.busy) begin
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One-cycle pulse for each write that arrives while the FIFO is full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= bus.wr_en && w_full;
        end
    end

    assign bus.TX_Data  = r_tx_data;
    assign bus.transmit = r_transmit;
    assign bus.overflow = r_overflow;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = w_count;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized scoreboard bench for uart_tx_buffer. A behavioural model keeps
// the queued bytes in a queue and decides each edge, from the handshake timing
// rules, when the next byte must be launched; a transmitter model drives busy.
module tb_uart_tx_buffer;
    localparam int DEPTH = 16;
    localparam int DW    = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_tx_buffer_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    uart_tx_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    int              m_count  = 0;
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   last_tx  = '0;
    bit              in_req   = 0;
    bit              in_send  = 0;
    int              earliest = 0;
    bit              exp_ovf  = 0;

    // Transmitter model controls
    bit tx_stall = 0;
    bit tx_hold  = 0;
    bit tx_abort = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard: sample inputs at the edge, outputs 1 time unit later.
    always @(posedge clk) begin : monitor
        logic          p_rst;
        logic          p_wr;
        logic          p_busy;
        logic [DW-1:0] p_data;
        bit            accept;
        p_rst  = reset;
        p_wr   = bus.wr_en;
        p_busy = bus.busy;
        p_data = bus.wr_data;
        cyc++;
        #1;
        if (!p_rst) begin
            m_count  = 0;
            exp_q.delete();
            last_tx  = '0;
            in_req   = 0;
            in_send  = 0;
            earliest = 0;
            exp_ovf  = 0;
        end else begin
            accept  = p_wr && (m_count < DEPTH);
            exp_ovf = p_wr && (m_count == DEPTH);
            if (in_req) begin
                if (p_busy) begin
                    in_req  = 0;
                    in_send = 1;
                end
            end else if (in_send) begin
                if (!p_busy) begin
                    in_send  = 0;
                    earliest = cyc + 2;
                end
            end else if (cyc >= earliest && m_count > 0) begin
                in_req  = 1;
                last_tx = exp_q.pop_front();
                m_count--;
            end
            if (accept) begin
                exp_q.push_back(p_data);
                m_count++;
            end
        end
        check("transmit", bus.transmit, in_req);
        check("TX_Data",  bus.TX_Data,  last_tx);
        check("count",    bus.count,    m_count);
        check("full",     bus.full,     m_count == DEPTH);
        check("empty",    bus.empty,    m_count == 0);
        check("overflow", bus.overflow, exp_ovf);
    end

    // Transmitter model: raises busy 0-2 cycles after seeing transmit, keeps it
    // until transmit drops, then holds 0-3 more cycles.
    initial begin : tx_model
        int ph;
        int dly;
        ph       = 0;
        dly      = 0;
        bus.busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_abort) begin
                tx_abort = 0;
                ph       = 0;
                bus.busy = 1'b0;
            end else begin
                case (ph)
                    0: if (bus.transmit && !tx_stall) begin
                        dly = $urandom_range(0, 2);
                        ph  = 1;
                        if (dly == 0) begin
                            bus.busy = 1'b1;
                            ph       = 2;
                        end
                    end
                    1: begin
                        dly--;
                        if (dly <= 0) begin
                            bus.busy = 1'b1;
                            ph       = 2;
                        end
                    end
                    2: if (!bus.transmit && !tx_hold) begin
                        dly = $urandom_range(0, 3);
                        ph  = 3;
                        if (dly == 0) begin
                            bus.busy = 1'b0;
                            ph       = 0;
                        end
                    end
                    default: begin
                        dly--;
                        if (dly <= 0) begin
                            bus.busy = 1'b0;
                            ph       = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic wr(input logic [DW-1:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
    endtask

    task automatic wr_idle();
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        bus.busy  = 1'b0;
        tx_abort  = 1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(m_count == 0 && !in_req && !in_send) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 3000, 1);
    endtask

    initial begin : stimulus
        int n;
        reset       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single byte
        wr(8'hA5);
        wr_idle();
        wait_drain("single_drain");

        // Burst to full while the transmitter stalls, then overflow with FF
        tx_stall = 1;
        wr(8'hEE);
        wr_idle();
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
        end
        wr(8'hFF);
        wr_idle();
        repeat (2) @(negedge clk);
        check("burst_full",  bus.full,  1);
        check("burst_count", bus.count, 16);
        tx_stall = 0;
        wait_drain("burst_drain");
        check("burst_empty", bus.empty, 1);

        // Writes landing on pop edges
        tx_stall = 1;
        wr(8'hE1);
        for (int i = 0; i < 3; i++) begin
            wr(8'($urandom));
        end
        wr_idle();
        tx_stall = 0;
        for (int i = 0; i < 12; i++) begin
            wr(8'h3C + 8'(i));
        end
        wr_idle();
        wait_drain("same_edge_drain");

        // Reset while in SEND with five bytes queued
        tx_hold = 1;
        for (int i = 0; i < 6; i++) begin
            wr(8'h70 + 8'(i));
        end
        wr_idle();
        n = 0;
        while (!(in_send && m_count == 5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_send", n < 200, 1);
        tx_hold = 0;
        do_reset();
        check("rst_transmit", bus.transmit, 0);
        check("rst_count",    bus.count,    0);
        check("rst_empty",    bus.empty,    1);
        check("rst_txdata",   bus.TX_Data,  0);
        wr(8'h5A);
        wr_idle();
        wait_drain("post_reset_drain");

        // Wrap-around: bursts of 10 random bytes with drains between
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                wr(8'($urandom));
            end
            wr_idle();
            wait_drain("wrap_drain");
        end

        // Random traffic with intermittent transmitter stalls
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bus.wr_en   = ($urandom_range(0, 9) < 6);
            bus.wr_data = 8'($urandom);
            if (i % 25 == 0) begin
                tx_stall = ($urandom_range(0, 2) == 0);
            end
        end
        wr_idle();
        tx_stall = 0;
        wait_drain("random_drain");
        check("final_empty", bus.empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
